st7735_init_seq: RTL

Init sequencer for the ST7735 128x160 SPI TFT; it sits between `st7735_init_rom` and the SPI byte transmitter. On `start` it pulses the panel hardware reset and walks ROM indices 0..N-1. Each non-padding entry is presented to the transmitter over a valid/ready handshake, with the mandatory post-SWRESET and post-SLPOUT waits inserted. It raises `done` when the panel is initialised and ready for pixel traffic.

---
 rtl/st7735_init_if.sv | 22 ++
 rtl/st7735_init_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/st7735_init_if.sv
// Byte handshake between the init sequencer and the SPI byte transmitter.
// The sequencer is the master and offers bytes; the transmitter is the slave.
interface st7735_init_seq_if;
    logic       tx_valid;
    logic       tx_is_data;
    logic [7:0] tx_byte;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_is_data,
        output tx_byte,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_is_data,
        input  tx_byte,
        output tx_ready
    );
endinterface

// File: rtl/st7735_init_seq.sv
// ST7735 init sequencer: hardware reset pulse, then ROM walk to the SPI
// transmitter, with the SWRESET/SLPOUT settle delays inserted.
module st7735_init_seq #(
    parameter int N                = 22,
    parameter int RST_LOW_CYC      = 500,
    parameter int RST_WAIT_CYC     = 6_000_000,
    parameter int SWRESET_WAIT_CYC = 7_500_000,
    parameter int SLPOUT_WAIT_CYC  = 6_000_000,
    localparam int IW = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [IW-1:0]            rom_idx,
    input  logic                     rom_is_data,
    input  logic [7:0]               rom_byte,
    st7735_init_seq_if.master        tx,
    output logic                     lcd_rst_n,
    output logic                     busy,
    output logic                     done
);

    localparam int M0   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int M1   = (SWRESET_WAIT_CYC > SLPOUT_WAIT_CYC) ?
                          SWRESET_WAIT_CYC : SLPOUT_WAIT_CYC;
    localparam int MAXC = (M0 > M1) ? M0 : M1;
    localparam int CW   = $clog2(MAXC + 2);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [2:0] {
        IDLE, RST_LOW, RST_WAIT, LOAD, SEND, WAIT_TX, DELAY, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          dc_q, dc_d;
    logic [7:0]    byte_q, byte_d;
    logic          lcd_q, lcd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          adv;
    logic          pad;
    logic          wait_cmd;

    // A zero cycle count still occupies its state for one cycle.
    function automatic logic [CW-1:0] ld(input int c);
        return (c <= 0) ? CW'(1) : CW'(c);
    endfunction

    assign pad      = !rom_is_data && (rom_byte == 8'h00);
    assign wait_cmd = !dc_q && (byte_q == 8'h01 || byte_q == 8'h11);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        dc_d    = dc_q;
        byte_d  = byte_q;
        adv     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RST_LOW;
                    idx_d   = '0;
                    cnt_d   = ld(RST_LOW_CYC);
                end
            end
            RST_LOW: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = RST_WAIT;
                    cnt_d   = ld(RST_WAIT_CYC);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RST_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LOAD: begin
                if (pad) begin
                    adv = 1'b1;
                end else begin
                    byte_d  = rom_byte;
                    dc_d    = rom_is_data;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (valid_q && tx.tx_ready) begin
                    valid_d = 1'b0;
                    if (wait_cmd) state_d = WAIT_TX;
                    else adv = 1'b1;
                end
            end
            WAIT_TX: begin
                // Delay is timed from the end of the last shifted bit.
                if (tx.tx_ready) begin
                    state_d = DELAY;
                    cnt_d   = (byte_q == 8'h01) ? ld(SWRESET_WAIT_CYC)
                                                : ld(SLPOUT_WAIT_CYC);
                end
            end
            DELAY: begin
                if (cnt_q <= CW'(1)) begin
                    adv   = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            if (idx_q == LAST) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_q + IW'(1);
                state_d = LOAD;
            end
        end
        busy_d = !(state_d == IDLE || state_d == DONE);
        done_d = (state_d == DONE);
        lcd_d  = !(state_d == IDLE || state_d == RST_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            dc_q    <= 1'b0;
            byte_q  <= 8'h00;
            lcd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dc_q    <= dc_d;
            byte_q  <= byte_d;
            lcd_q   <= lcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rom_idx       = idx_q;
    assign tx.tx_valid   = valid_q;
    assign tx.tx_is_data = dc_q;
    assign tx.tx_byte    = byte_q;
    assign lcd_rst_n     = lcd_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
